// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style controller: steps fetch/decode/execute/memory/write-back, one state per clock.
// Latency: outputs follow the state register; lw 5 cycles, sw/R/addi/lui/in/jal 4, beq/bne/j/jr 3.
// No backpressure: advances every clock; the optional bne dispatch is enabled by macro CTRL_BNE_EN.
module mc_control_fsm #(
  parameter int                 STATE_W     = 4,
  parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(0)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       RegWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] gpio_i,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),  S_DECODE  = STATE_W'(1),  S_MEMADR = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),  S_MEMWB   = STATE_W'(4),  S_MEMWRITE = STATE_W'(5),
    S_EXECUTE  = STATE_W'(6),  S_ALUWB   = STATE_W'(7),  S_BRANCH = STATE_W'(8),
    S_IEXEC    = STATE_W'(9),  S_IWB     = STATE_W'(10), S_JUMP   = STATE_W'(11),
    S_JALEX    = STATE_W'(12), S_JALWB   = STATE_W'(13), S_JR     = STATE_W'(14),
    S_UNUSED   = STATE_W'(15)
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] gpio_i;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       branch;     // PC write qualified by Zero
    logic       bne;        // invert the Zero qualification
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_IN   = 6'b111111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Control word for a given state; Op/Funct only refine ALU op and immediate select.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = 3'b010;
    case (s)
      S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
      S_DECODE:   begin c.alu_src_b = 2'b11; c.gpio_i = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.gpio_i = 2'b01; end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        case (funct)
          6'b100010: c.alu_ctrl = 3'b110;
          6'b100100: c.alu_ctrl = 3'b000;
          6'b100101: c.alu_ctrl = 3'b001;
          6'b101010: c.alu_ctrl = 3'b111;
          default:   c.alu_ctrl = 3'b010;
        endcase
      end
      S_ALUWB:    begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.branch = 1'b1;
`ifdef CTRL_BNE_EN
        c.bne = (op == OP_BNE);
`endif
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.gpio_i = (op == OP_LUI) ? 2'b00 : (op == OP_IN) ? 2'b10 : 2'b01;
      end
      S_IWB:      c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_JALEX:    begin c.alu_src_b = 2'b10; c.gpio_i = 2'b11; end
      S_JALWB:    begin c.reg_dst = 2'b10; c.reg_write = 1'b1; c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_JR:       begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.gpio_i = 2'b11; c.pc_write = 1'b1; end
      default:    c = c;
    endcase
    return c;
  endfunction

  state_t state, next_state;
  ctrl_t  ctrl_q, ctrl_out;
  logic   illegal_q, next_illegal;

  // Next-state selection; unsupported Op/Funct returns to FETCH and flags illegal.
  always_comb begin
    next_state   = S_FETCH;
    next_illegal = 1'b0;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:          next_state = S_MEMADR;
          OP_R:                  next_state = (Funct == FN_JR) ? S_JR : S_EXECUTE;
`ifdef CTRL_BNE_EN
          OP_BEQ, OP_BNE:        next_state = S_BRANCH;
`else
          OP_BEQ:                next_state = S_BRANCH;
`endif
          OP_ADDI, OP_LUI, OP_IN: next_state = S_IEXEC;
          OP_J:                  next_state = S_JUMP;
          OP_JAL:                next_state = S_JALEX;
          default:               next_illegal = 1'b1;
        endcase
      end
      S_MEMADR:  next_state = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: next_state = S_MEMWB;
      S_EXECUTE: begin
        case (Funct)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: next_state = S_ALUWB;
          default: next_illegal = 1'b1;
        endcase
      end
      S_IEXEC:   next_state = S_IWB;
      S_JALEX:   next_state = S_JALWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // State register with the control word registered alongside for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= state_t'(RESET_STATE);
      ctrl_q    <= decode(state_t'(RESET_STATE), 6'd0, 6'd0);
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      ctrl_q    <= decode(next_state, Op, Funct);
      illegal_q <= next_illegal;
    end
  end

  // Every output is held at zero while reset is asserted.
  assign ctrl_out   = reset ? ctrl_q : '0;
  assign PCWrite    = ctrl_out.pc_write | (ctrl_out.branch & (Zero ^ ctrl_out.bne));
  assign PCSrc      = ctrl_out.pc_src;
  assign RegWrite   = ctrl_out.reg_write;
  assign IorD       = ctrl_out.iord;
  assign MemWrite   = ctrl_out.mem_write;
  assign IRWrite    = ctrl_out.ir_write;
  assign RegDst     = ctrl_out.reg_dst;
  assign MemtoReg   = ctrl_out.mem_to_reg;
  assign ALUSrcA    = ctrl_out.alu_src_a;
  assign gpio_i     = ctrl_out.gpio_i;
  assign ALUSrcB    = ctrl_out.alu_src_b;
  assign ALUControl = ctrl_out.alu_ctrl;
  assign state_o    = 4'(state);
  assign illegal_o  = illegal_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle controller that sequences the 32-bit MIPS-style datapath: fetch, decode, execute, memory and write-back, one state per clock.
- Takes Op/Funct/Zero from the datapath and drives every datapath control input (PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUControl, immediate select gpio_i).
- Moore machine: all outputs are decoded from the current state only; branch-taken combines Zero internally.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH)
- STATE_W, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Op  in  6  Instr[31:26]
- Funct  in  6  Instr[5:0]
- Zero  in  1  datapath ALUResult==0
- PCWrite  out  1  PC register enable (already combined with branch/Zero)
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- RegWrite  out  1  register file write
- IorD  out  1  0 PC address, 1 ALUOut address
- MemWrite  out  1  memory write
- IRWrite  out  1  instruction register enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  1  0 ALUOut, 1 Data
- ALUSrcA  out  1  0 PC, 1 A
- gpio_i  out  2  immediate select: 00 imm<<16, 01 sext16, 10 sext8 switches, 11 zero
- ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state_o  out  4  current state encoding (debug)
- illegal_o  out  1  one-cycle pulse: unsupported opcode/funct decoded

Behaviour:
- Reset: state=FETCH(0), illegal_o=0. All enables (PCWrite, RegWrite, MemWrite, IRWrite) are forced 0 while reset=0. Every other output is 0 while reset=0. Reset mid-instruction aborts it; the next cycle after release is FETCH.
- Unlisted outputs in a state are 0 (ALUControl=010).
- States and outputs:
  - 0 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, PCWrite=1 -> DECODE
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, gpio_i=01, add (ALUOut <= branch target). Dispatch on Op:
    - lw 100011 / sw 101011 -> MEMADR
    - R 000000 -> EXECUTE; with Funct 001000 -> JR
    - beq 000100 -> BRANCH
    - addi 001000 / lui 001111 / in 111111 -> IEXEC
    - j 000010 -> JUMP
    - jal 000011 -> JALEX
    - else -> FETCH with illegal_o=1 on the next cycle
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, gpio_i=01, add -> lw: MEMREAD; sw: MEMWRITE
  - 3 MEMREAD: IorD=1 -> MEMWB
  - 4 MEMWB: RegDst=00, MemtoReg=1, RegWrite=1 -> FETCH
  - 5 MEMWRITE: IorD=1, MemWrite=1 -> FETCH
  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00. Funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other Funct -> FETCH with illegal_o -> ALUWB
  - 7 ALUWB: RegDst=01, MemtoReg=0, RegWrite=1 -> FETCH
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero -> FETCH
  - 9 IEXEC: ALUSrcA=1, ALUSrcB=10, add; gpio_i=01 addi, 00 lui (rs encoded 0), 10 in (rt=rs+sext(switches)) -> IWB
  - 10 IWB: RegDst=00, MemtoReg=0, RegWrite=1 -> FETCH
  - 11 JUMP: PCSrc=10, PCWrite=1 -> FETCH
  - 12 JALEX: ALUSrcA=0, ALUSrcB=10, gpio_i=11, add (ALUOut <= PC+4) -> JALWB
  - 13 JALWB: RegDst=10, MemtoReg=0, RegWrite=1, PCSrc=10, PCWrite=1 -> FETCH
  - 14 JR: ALUSrcA=1, ALUSrcB=10, gpio_i=11, add, PCSrc=00, PCWrite=1 -> FETCH
  - 15: unused; if ever reached -> FETCH
- Instruction latencies (cycles): lw 5; sw, R, addi, lui, in, jal 4; beq, j, jr 3.
- illegal_o is registered: high exactly one cycle, coinciding with the following FETCH.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined: Op 000101 (bne) dispatches to BRANCH with PCWrite = ~Zero.
- Undefined: 000101 is illegal (illegal_o pulse, return to FETCH, no PC/register/memory write beyond FETCH).

Test Plan:
- Reset: hold reset=0 three cycles with Op=100011 -> state_o=0, all enables 0; release -> FETCH outputs, then DECODE.
- lw: Op=100011 -> state sequence 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4; IorD=1 in 3.
- beq: Op=000100, Zero=1 -> PCWrite=1, PCSrc=01 in state 8. Repeat with Zero=0 -> PCWrite=0. 3 cycles each.
- R-type: Funct 101010 -> ALUControl=111 in EXECUTE; Funct 001000 -> state 14, PCSrc=00. Funct 000111 -> illegal_o high one cycle, back to FETCH.
- jal: Op=000011 -> states 0,1,12,13; gpio_i=11 in 12; RegDst=10, PCSrc=10, PCWrite=1 in 13.
- bne (Op=000101), Zero=0: CTRL_BNE_EN defined -> PCWrite=1 in state 8; undefined -> illegal_o pulse, no state 8.
